ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter, the write direction of the keyboard link that ps2_keyboard currently only receives on. It sends single command bytes to the keyboard (0xED set-LEDs, 0xFF reset, 0xF3 typematic) using the open-drain PS/2 request-to-send protocol, and reports acknowledge or error. It sits beside ps2_keyboard on the same PS2_CLK/PS2_DAT pins. While busy=1, ps2_keyboard ignores the bus.

Parameters:
INHIBIT_CYC, 6000, cycles of clock-line inhibit before the request (120 us at 50 MHz).
REQ_CYC, 16, cycles in which clock and data are both held low before the clock is released.
TIMEOUT_CYC, 1000000, maximum cycles from clock release to frame completion (20 ms at 50 MHz).
FILT_LEN, 8, consecutive equal samples needed before a filtered line changes state.

Ports:
clk  in  1  system clock, the same 50 MHz clk used by ps2_keyboard.
reset  in  1  synchronous, active-low reset.
tx_data  in  8  command byte.
tx_valid  in  1  request to send tx_data.
tx_ready  out  1  high only in IDLE; a byte is accepted when tx_valid and tx_ready are both high.
busy  out  1  high from acceptance until done or err.
done  out  1  one-cycle pulse when the device acknowledged and the bus returned to idle.
err  out  1  one-cycle pulse on failure.
err_code  out  2  valid with err: 01 = timeout, 10 = no acknowledge; holds until the next acceptance.
ps2_clk_in  in  1  raw PS2_CLK pin level.
ps2_dat_in  in  1  raw PS2_DAT pin level.
ps2_clk_oe  out  1  1 drives PS2_CLK low; 0 releases it.
ps2_dat_oe  out  1  1 drives PS2_DAT low; 0 releases it.

Behaviour:
- Reset (reset=0 at a rising edge of clk):
  - State goes to IDLE.
  - ps2_clk_oe, ps2_dat_oe, busy, done, err, err_code all go to 0; tx_ready goes to 1.
  - Reset mid-frame releases both lines on that same edge. No done or err is emitted.
- Input conditioning:
  - Each pin passes through a 2-FF synchronizer, then a filter that requires FILT_LEN consecutive equal samples before it changes.
  - fall_clk is a one-cycle pulse on a filtered clock transition from 1 to 0.
- Odd parity: parity bit = ~^tx_data.
- States:
  - IDLE: on handshake, latch tx_data and parity, set busy=1 on the next cycle, go to INHIBIT.
  - INHIBIT: clk_oe=1, dat_oe=0 for exactly INHIBIT_CYC cycles, then go to REQ.
  - REQ: clk_oe=1, dat_oe=1 for REQ_CYC cycles. Then clk_oe=0 (dat_oe stays 1 as the start bit), clear the timeout counter and bit index, go to SEND.
  - SEND: on fall_clk number k:
    - k=1..8: dat_oe = ~tx_data[k-1] (LSB first).
    - k=9: dat_oe = ~parity.
    - k=10: dat_oe=0 (stop bit).
    - k=11: sample the filtered data line; 0 means ack. Go to WAIT_IDLE.
    - Between edges dat_oe holds its value.
  - WAIT_IDLE: wait until both filtered lines are 1. Then pulse done (ack) or pulse err with code 10 (no ack), and go to IDLE.
- Timeout: the counter runs in SEND and WAIT_IDLE. If it reaches TIMEOUT_CYC:
  - release both lines;
  - pulse err with err_code=01;
  - go to IDLE.
  - Timeout takes priority over a fall_clk in the same cycle.
- tx_valid while busy is ignored; there is no queue.
- done and err are never high in the same cycle.
- Acceptance latency: tx_ready falls on the cycle after the handshake.
- Whole-frame duration is set by the device clock (about 1.1 ms at 10 kHz).

Decomposition:
- Package ps2_defs holds:
  - state encodings: IDLE, INHIBIT, REQ, SEND, WAIT_IDLE;
  - ERR_TIMEOUT = 2'b01, ERR_NOACK = 2'b10;
  - LAST_BIT = 11.
- Sub-module ps2_line_filter (synchronizer plus FILT_LEN filter) is instantiated twice, once per line. It outputs the filtered level and a fall pulse. ps2_keyboard is to reuse it.

Test Plan:
Bench parameters: INHIBIT_CYC=100, REQ_CYC=16, TIMEOUT_CYC=5000, FILT_LEN=4. The device model drives a 40-cycle clock half-period.
1. Send 0xED with ack -> clk_oe high for 100 cycles, then REQ. Device samples on rising edges: start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Model pulls data low -> one done pulse, err=0, tx_ready returns to 1.
2. Send 0x07 -> parity bit sampled = 0. Send 0x00 -> parity bit sampled = 1. Both end in done.
3. Device never clocks after REQ -> exactly 5000 cycles after clock release: err=1 for one cycle, err_code=01, both oe=0.
4. Device completes 11 clocks but leaves data high -> err pulse with err_code=10 once both lines are idle; no done.
5. reset=0 during bit 4 -> both oe=0 and state IDLE on that edge, no done/err. A following 0xFF transfer completes normally with parity 1.
6. tx_valid held high during a transfer and 3-cycle glitches on ps2_clk_in -> no second transfer starts and glitches create no extra bit shifts; sampled bits match tx_data.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, error codes
// and the odd-parity helper.
package ps2_defs;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    WAIT_IDLE
  } state_t;

  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NOACK   = 2'b10;
  localparam int         LAST_BIT    = 11;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake and status between a host controller and ps2_host_tx.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, err, err_code
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, err, err_code
  );
endinterface

// File: rtl/ps2_host_tx_line_filter.sv
// 2-FF synchronizer plus run-length glitch filter for one PS/2 line.
// Idle level of an open-drain PS/2 line is 1, so the filter resets to 1.
module ps2_line_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall
);
  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1   <= i_pin;
      r_s2   <= r_s1;
      r_fall <= 1'b0;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILT_LEN - 1)) begin
        // A change always inverts the level, so a fall is a change away from 1.
        r_level <= r_s2;
        r_fall  <= r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clocks out
// start/8 data/parity/stop on device clock falls, then checks the device ack.
module ps2_host_tx
  import ps2_defs::*;
#(
  parameter int INHIBIT_CYC = 6000,
  parameter int REQ_CYC     = 16,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int FILT_LEN    = 8
) (
  input  logic          clk,
  input  logic          reset,
  ps2_host_tx_if.slave  bus,
  input  logic          ps2_clk_in,
  input  logic          ps2_dat_in,
  output logic          ps2_clk_oe,
  output logic          ps2_dat_oe
);
  localparam int CNT_W = $clog2(INHIBIT_CYC + REQ_CYC + TIMEOUT_CYC + 1);

  logic w_clk_lvl;
  logic w_clk_fall;
  logic w_dat_lvl;
  logic w_unused_dat_fall;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk(clk), .reset(reset), .i_pin(ps2_clk_in),
    .o_level(w_clk_lvl), .o_fall(w_clk_fall)
  );

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
    .clk(clk), .reset(reset), .i_pin(ps2_dat_in),
    .o_level(w_dat_lvl), .o_fall(w_unused_dat_fall)
  );

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit;
  logic [7:0]       r_data;
  logic             r_par;
  logic             r_ack;
  logic             r_clk_oe;
  logic             r_dat_oe;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [1:0]       r_err_code;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_ack      <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_dat_oe   <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.tx_valid && r_ready) begin
            r_data     <= bus.tx_data;
            r_par      <= odd_parity(bus.tx_data);
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_err_code <= 2'b00;
            r_clk_oe   <= 1'b1;
            r_dat_oe   <= 1'b0;
            r_cnt      <= '0;
            r_state    <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (r_cnt == CNT_W'(INHIBIT_CYC - 1)) begin
            r_cnt    <= '0;
            r_dat_oe <= 1'b1;
            r_state  <= REQ;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        REQ: begin
          // Releasing the clock with data still low presents the start bit.
          if (r_cnt == CNT_W'(REQ_CYC - 1)) begin
            r_cnt    <= '0;
            r_bit    <= '0;
            r_clk_oe <= 1'b0;
            r_state  <= SEND;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SEND, WAIT_IDLE: begin
          if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_err      <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_state == SEND) begin
              if (w_clk_fall) begin
                r_bit <= r_bit + 1'b1;
                if (r_bit < 4'd8) begin
                  r_dat_oe <= ~r_data[r_bit[2:0]];
                end else if (r_bit == 4'd8) begin
                  r_dat_oe <= ~r_par;
                end else if (r_bit == 4'd9) begin
                  r_dat_oe <= 1'b0;
                end else begin
                  r_ack   <= ~w_dat_lvl;
                  r_state <= WAIT_IDLE;
                end
              end
            end else if (w_clk_lvl && w_dat_lvl) begin
              if (r_ack) begin
                r_done <= 1'b1;
              end else begin
                r_err      <= 1'b1;
                r_err_code <= ERR_NOACK;
              end
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ps2_clk_oe   = r_clk_oe;
  assign ps2_dat_oe   = r_dat_oe;
  assign bus.tx_ready = r_ready;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.err_code = r_err_code;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
  import ps2_defs::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic dev_clk_low;
  logic dev_dat_low;
  logic glitch_low;
  logic clk_oe;
  logic dat_oe;
  logic bus_clk;
  logic bus_dat;
  logic ps2_clk_in;
  logic ps2_dat_in;

  assign bus_clk    = !(clk_oe || dev_clk_low);
  assign bus_dat    = !(dat_oe || dev_dat_low);
  assign ps2_clk_in = bus_clk && !glitch_low;
  assign ps2_dat_in = bus_dat;

  ps2_host_tx_if u_if ();

  ps2_host_tx #(
    .INHIBIT_CYC(100), .REQ_CYC(16), .TIMEOUT_CYC(5000), .FILT_LEN(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(u_if.slave),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(clk_oe), .ps2_dat_oe(dat_oe)
  );

  int total = 0;
  int bad   = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, hs_cnt = 0;

  always @(posedge clk) begin
    if (u_if.done) done_cnt <= done_cnt + 1;
    if (u_if.err) err_cnt <= err_cnt + 1;
    if (u_if.done && u_if.err) both_cnt <= both_cnt + 1;
    if (u_if.tx_valid && u_if.tx_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  task automatic send(input logic [7:0] d, input bit hold);
    @(negedge clk);
    u_if.tx_data  = d;
    u_if.tx_valid = 1'b1;
    @(negedge clk);
    if (!hold) u_if.tx_valid = 1'b0;
  endtask

  // Device: samples start at clock release, then data on each rising edge.
  task automatic dev_frame(input int nclk, input bit ack, input bit glitch,
                           output logic [10:0] smp);
    int n = 0;
    while (!(clk_oe == 1'b0 && dat_oe == 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rts_seen", 32'(n < 2000), 32'd1);
    smp    = '0;
    smp[0] = bus_dat;
    repeat (40) @(negedge clk);
    for (int k = 1; k <= nclk; k++) begin
      dev_clk_low = 1'b1;
      repeat (40) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) smp[k] = bus_dat;
      if (k == 11) begin
        dev_dat_low   = 1'b0;
        u_if.tx_valid = 1'b0;
      end
      if (glitch) begin
        repeat (10) @(negedge clk);
        glitch_low = 1'b1;
        repeat (3) @(negedge clk);
        glitch_low = 1'b0;
        repeat (7) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      if (k == 10 && ack) dev_dat_low = 1'b1;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (u_if.busy && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 8000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [10:0] smp;
    int n, d0, e0, h0;
    reset = 1'b0;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    glitch_low  = 1'b0;
    u_if.tx_data  = 8'h00;
    u_if.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(u_if.tx_ready), 32'd1);
    check("rst_busy", 32'(u_if.busy), 32'd0);
    check("rst_oe", {30'd0, clk_oe, dat_oe}, 32'd0);
    check("rst_pulses", {30'd0, u_if.done, u_if.err}, 32'd0);
    check("rst_code", 32'(u_if.err_code), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // 1: 0xED with ack, inhibit and request timing
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED, 1'b0);
    check("accept_ready", 32'(u_if.tx_ready), 32'd0);
    check("accept_busy", 32'(u_if.busy), 32'd1);
    n = 0;
    while (clk_oe && !dat_oe && n < 1000) begin n++; @(negedge clk); end
    check("inhibit_len", 32'(n), 32'd100);
    n = 0;
    while (clk_oe && dat_oe && n < 1000) begin n++; @(negedge clk); end
    check("req_len", 32'(n), 32'd16);
    dev_frame(11, 1'b1, 1'b0, smp);
    check("frame_ED", 32'(smp), 32'(frame_of(8'hED)));
    wait_idle("end_ED");
    check("done_ED", 32'(done_cnt - d0), 32'd1);
    check("err_ED", 32'(err_cnt - e0), 32'd0);
    check("ready_ED", 32'(u_if.tx_ready), 32'd1);

    // 2: parity 0 and parity 1
    d0 = done_cnt;
    send(8'h07, 1'b0);
    dev_frame(11, 1'b1, 1'b0, smp);
    check("par_07", 32'(smp[9]), 32'd0);
    check("frame_07", 32'(smp), 32'(frame_of(8'h07)));
    wait_idle("end_07");
    send(8'h00, 1'b0);
    dev_frame(11, 1'b1, 1'b0, smp);
    check("par_00", 32'(smp[9]), 32'd1);
    wait_idle("end_00");
    check("done_07_00", 32'(done_cnt - d0), 32'd2);

    // 3: device never clocks -> timeout
    d0 = done_cnt;
    send(8'h3C, 1'b0);
    n = 0;
    while (!(clk_oe == 1'b0 && dat_oe == 1'b1) && n < 2000) begin @(negedge clk); n++; end
    check("to_release", 32'(n < 2000), 32'd1);
    n = 0;
    while (!u_if.err && n < 6000) begin @(negedge clk); n++; end
    check("to_cycles", 32'(n), 32'd5000);
    check("to_code", 32'(u_if.err_code), 32'(ERR_TIMEOUT));
    check("to_oe", {30'd0, clk_oe, dat_oe}, 32'd0);
    check("to_nodone", 32'(u_if.done), 32'd0);
    @(negedge clk);
    check("to_err_1cyc", 32'(u_if.err), 32'd0);
    check("to_ready", 32'(u_if.tx_ready), 32'd1);
    check("to_code_hold", 32'(u_if.err_code), 32'(ERR_TIMEOUT));

    // 4: no acknowledge
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF3, 1'b0);
    check("code_clear", 32'(u_if.err_code), 32'd0);
    dev_frame(11, 1'b0, 1'b0, smp);
    check("frame_F3", 32'(smp), 32'(frame_of(8'hF3)));
    wait_idle("end_F3");
    check("noack_err", 32'(err_cnt - e0), 32'd1);
    check("noack_done", 32'(done_cnt - d0), 32'd0);
    check("noack_code", 32'(u_if.err_code), 32'(ERR_NOACK));

    // 5: reset mid-frame, then 0xFF
    d0 = done_cnt; e0 = err_cnt;
    send(8'h12, 1'b0);
    dev_frame(4, 1'b1, 1'b0, smp);
    check("pre_rst_datoe", 32'(dat_oe), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_oe", {30'd0, clk_oe, dat_oe}, 32'd0);
    check("mid_rst_ready", 32'(u_if.tx_ready), 32'd1);
    check("mid_rst_busy", 32'(u_if.busy), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_rst_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    send(8'hFF, 1'b0);
    dev_frame(11, 1'b1, 1'b0, smp);
    check("frame_FF", 32'(smp), 32'(frame_of(8'hFF)));
    wait_idle("end_FF");
    check("done_FF", 32'(done_cnt - d0), 32'd1);

    // 6: tx_valid held, data changed while busy, clock glitches
    d0 = done_cnt; h0 = hs_cnt;
    send(8'hA5, 1'b1);
    u_if.tx_data = 8'h00;
    dev_frame(11, 1'b1, 1'b1, smp);
    check("frame_A5", 32'(smp), 32'(frame_of(8'hA5)));
    wait_idle("end_A5");
    check("hold_hs", 32'(hs_cnt - h0), 32'd1);
    check("done_A5", 32'(done_cnt - d0), 32'd1);
    check("busy_A5", 32'(u_if.busy), 32'd0);
    check("never_both", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
